// File: rtl/sdram_session_arbiter.sv
// Round-robin session arbiter for the shared SDRAM read/write glue port.
// A requester opens a session with req/ack, owns the mux until it signals
// done, and a watchdog forcibly ends sessions whose owner never finishes.
module sdram_session_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 4096,
    parameter int TO_W       = 13,
    parameter int PRIO_PORT0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] iReq,
    output logic [NUM_PORTS-1:0] oAck,
    input  logic [NUM_PORTS-1:0] iDone,
    output logic [NUM_PORTS-1:0] oGrant,
    output logic [SEL_W-1:0]     oSel,
    output logic                 oBusy,
    output logic                 oTimeout,
    output logic [SEL_W-1:0]     oErr_Port,
    output logic                 oErr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     rr_q, rr_d;
    logic [SEL_W-1:0]     err_port_q, err_port_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic                 err_q, err_d;
    logic [TO_W-1:0]      wd_q, wd_d;

    logic                 win_found;
    logic [SEL_W-1:0]     win_sel;
    logic [NUM_PORTS-1:0] win_oh;
    logic                 owner_done;

    // Winner search: port 0 pre-empts when prioritised, else first request
    // at or after the round-robin pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        win_oh    = '0;
        if (PRIO_PORT0 != 0 && iReq[0]) begin
            win_found = 1'b1;
            win_sel   = '0;
            win_oh[0] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (!win_found && iReq[j] &&
                        (j == ((int'(rr_q) + i) % NUM_PORTS))) begin
                        win_found = 1'b1;
                        win_sel   = SEL_W'(j);
                        win_oh[j] = 1'b1;
                    end
                end
            end
        end
    end

    // Only the current owner's done counts; the grant is one-hot so a mask
    // selects it without an index that could run past NUM_PORTS.
    assign owner_done = |(iDone & grant_q);

    // Session FSM: next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        ack_d      = '0;
        timeout_d  = 1'b0;
        err_d      = err_q;
        err_port_d = err_port_q;
        rr_d       = rr_q;
        wd_d       = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (en && win_found) begin
                    grant_d = win_oh;
                    sel_d   = win_sel;
                    busy_d  = 1'b1;
                    ack_d   = win_oh;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the limit cycle wins over the watchdog.
                if (owner_done) begin
                    state_d = S_RELEASE;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    err_d      = 1'b1;
                    err_port_d = sel_q;
                    state_d    = S_RELEASE;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            S_RELEASE: begin
                // sel is left as-is; consumers qualify it with the grant.
                grant_d = '0;
                busy_d  = 1'b0;
                if (int'(sel_q) == NUM_PORTS - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = sel_q + SEL_W'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any session in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            sel_q      <= '0;
            rr_q       <= '0;
            err_port_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            err_port_q <= err_port_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
        end
    end

    assign oAck      = ack_q;
    assign oGrant    = grant_q;
    assign oSel      = sel_q;
    assign oBusy     = busy_q;
    assign oTimeout  = timeout_q;
    assign oErr_Port = err_port_q;
    assign oErr      = err_q;

endmodule
